// File: rtl/fifo_pkg.sv
// Shared types and defaults for the single-clock FIFO controllers.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned DEPTH_DEF     = 16;
  localparam int unsigned AE_THRESH_DEF = 2;

  // Pointer width includes one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_w(DEPTH_DEF)-1:0] ptr_t;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit FIFO pointer register with increment, load and async active-low clear.
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc,
  input  logic                      load,
  input  logic [ptr_w(DEPTH)-1:0]   load_val,
  output logic [ptr_w(DEPTH)-1:0]   ptr
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // Natural PW-bit overflow gives the modulo-2*DEPTH wrap for power-of-two depths.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: read pointer, occupancy flags, RAM read port, underflow.
// Define FIFO_RD_UFLOW_STICKY_EN to make underflow sticky until reset or flush.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        read_en,
  input  logic                        flush,
  input  logic [$clog2(DEPTH):0]      wr_ptr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        mem_re,
  output logic [$clog2(DEPTH)-1:0]    rd_addr,
  output logic [$clog2(DEPTH):0]      rd_ptr,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        almost_empty,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  output logic                        underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PW     = ADDR_W + 1;

  logic          accept;
  logic          rd_on_empty;
  logic [PW-1:0] rd_ptr_w;
  logic          data_valid_d, data_valid_q;
  logic          underflow_d, underflow_q;
  fifo_flags_t   flags;

  fifo_ptr_cnt #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk      (clk),
    .rst_n    (reset),
    .inc      (accept),
    .load     (flush),
    .load_val (wr_ptr),
    .ptr      (rd_ptr_w)
  );

  always_comb begin
    count              = wr_ptr - rd_ptr_w;
    flags.empty        = (count == '0);
    flags.almost_empty = (count <= PW'(AE_THRESH));
    flags.underflow    = underflow_q;
    accept             = read_en & ~flags.empty & ~flush;
    rd_on_empty        = read_en & flags.empty & ~flush;
  end

  always_comb begin
    data_valid_d = accept;
`ifdef FIFO_RD_UFLOW_STICKY_EN
    underflow_d  = flush ? 1'b0 : (underflow_q | rd_on_empty);
`else
    underflow_d  = rd_on_empty;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      data_valid_q <= data_valid_d;
      underflow_q  <= underflow_d;
    end
  end

  assign mem_re       = accept;
  assign rd_addr      = rd_ptr_w[ADDR_W-1:0];
  assign rd_ptr       = rd_ptr_w;
  assign empty        = flags.empty;
  assign almost_empty = flags.almost_empty;
  assign underflow    = flags.underflow;
  assign data_out     = mem_rdata;
  assign data_valid   = data_valid_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl (DEPTH=16) with a behavioural RAM and write side.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_en;
  logic       flush;
  logic [4:0] wr_ptr;
  logic [7:0] mem_rdata;
  logic       mem_re;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr;
  logic [4:0] count;
  logic       empty;
  logic       almost_empty;
  logic [7:0] data_out;
  logic       data_valid;
  logic       underflow;

  logic [7:0] mem [16];
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_read_ctrl #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read_en      (read_en),
    .flush        (flush),
    .wr_ptr       (wr_ptr),
    .mem_rdata    (mem_rdata),
    .mem_re       (mem_re),
    .rd_addr      (rd_addr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .empty        (empty),
    .almost_empty (almost_empty),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .underflow    (underflow)
  );

  // Synchronous RAM read port: data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[rd_addr];
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      assert (count <= 5'd16)
      else begin
        miscompares++;
        $error("FAIL count_overflow: got %0d, limit 16", count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  initial begin
    logic [7:0] d;
    reset     = 1'b0;
    read_en   = 1'b0;
    flush     = 1'b0;
    wr_ptr    = '0;
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset then idle
    repeat (3) step();
    chk("rst_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_uflow", 32'(underflow), 0);
    chk("rst_empty", 32'(empty), 1);
    reset = 1'b1;
    step();
    chk("idle_count", 32'(count), 0);
    chk("idle_empty", 32'(empty), 1);
    chk("idle_ae", 32'(almost_empty), 1);
    chk("idle_mem_re", 32'(mem_re), 0);
    chk("idle_dv", 32'(data_valid), 0);
    chk("idle_uflow", 32'(underflow), 0);

    // Fill and drain: zero-valued word must be readable
    push(8'h00); step();
    push(8'h5A); step();
    push(8'hFF); step();
    chk("fill_count", 32'(count), 3);
    chk("fill_empty", 32'(empty), 0);
    chk("fill_ae_3", 32'(almost_empty), 0);
    read_en = 1'b1;
    #1;
    chk("drain_mem_re", 32'(mem_re), 1);
    chk("drain_rd_addr", 32'(rd_addr), 0);
    step();
    chk("drain0_dv", 32'(data_valid), 1);
    chk("drain0_data", 32'(data_out), 32'h00);
    chk("drain0_ae_2", 32'(almost_empty), 1);
    step();
    chk("drain1_dv", 32'(data_valid), 1);
    chk("drain1_data", 32'(data_out), 32'h5A);
    step();
    chk("drain2_dv", 32'(data_valid), 1);
    chk("drain2_data", 32'(data_out), 32'hFF);
    chk("drain2_empty", 32'(empty), 1);
    chk("drain2_mem_re", 32'(mem_re), 0);
    chk("drain2_uflow", 32'(underflow), 0);
    step();
    chk("uflow_set", 32'(underflow), 1);
    chk("uflow_rd_ptr", 32'(rd_ptr), 3);
    chk("uflow_dv", 32'(data_valid), 0);
    read_en = 1'b0;
    step();
`ifndef FIFO_RD_UFLOW_STICKY_EN
    chk("uflow_pulse", 32'(underflow), 0);
`else
    chk("uflow_sticky", 32'(underflow), 1);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clr_uflow", 32'(underflow), 0);

    // Wrap: 40 write/read pairs starting at rd_ptr=3
    for (int i = 0; i < 40; i++) begin
      d = 8'((i * 37 + 11) & 8'hFF);
      push(d);
      read_en = 1'b1;
      #1;
      chk("wrap_empty", 32'(empty), 0);
      chk("wrap_count", 32'(count), 1);
      chk("wrap_mem_re", 32'(mem_re), 1);
      step();
      chk("wrap_rd_ptr", 32'(rd_ptr), 32'((3 + i + 1) % 32));
      chk("wrap_dv", 32'(data_valid), 1);
      chk("wrap_data", 32'(data_out), 32'(d));
    end
    read_en = 1'b0;
    chk("wrap_final_ptr", 32'(rd_ptr), 11);

    // Async reset mid-operation drops the pending data_valid
    push(8'hC3);
    read_en = 1'b1;
    step();
    chk("pre_rst_dv", 32'(data_valid), 1);
    chk("pre_rst_ptr", 32'(rd_ptr), 12);
    push(8'h3C);
    #3;
    reset  = 1'b0;
    wr_ptr = '0;
    #1;
    chk("async_rst_ptr", 32'(rd_ptr), 0);
    chk("async_rst_dv", 32'(data_valid), 0);
    chk("async_rst_empty", 32'(empty), 1);
    step();
    chk("rst_held_dv", 32'(data_valid), 0);
    read_en = 1'b0;
    reset   = 1'b1;
    step();

    // Full boundary: wr_ptr=16, rd_ptr=0
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    wr_ptr = 5'd16;
    #1;
    chk("full_count", 32'(count), 16);
    chk("full_empty", 32'(empty), 0);
    chk("full_ae", 32'(almost_empty), 0);
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("full_rd_count", 32'(count), 15);
    chk("full_rd_data", 32'(data_out), 32'h00);
    chk("full_rd_dv", 32'(data_valid), 1);
    step();
    chk("idle_dv_drop", 32'(data_valid), 0);

    // Flush plus read with count=5
    wr_ptr = 5'd6;
    #1;
    chk("pre_flush_count", 32'(count), 5);
    flush   = 1'b1;
    read_en = 1'b1;
    #1;
    chk("flush_mem_re", 32'(mem_re), 0);
    step();
    chk("flush_rd_ptr", 32'(rd_ptr), 6);
    chk("flush_count", 32'(count), 0);
    chk("flush_dv", 32'(data_valid), 0);
    chk("flush_uflow", 32'(underflow), 0);
    step();
    chk("flush_empty_rd_uflow", 32'(underflow), 0);
    flush   = 1'b0;
    read_en = 1'b0;

    // Almost-empty threshold edge
    wr_ptr = 5'd8;
    #1;
    chk("ae_at_2", 32'(almost_empty), 1);
    wr_ptr = 5'd9;
    #1;
    chk("ae_at_3", 32'(almost_empty), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ae_flush_ptr", 32'(rd_ptr), 9);

`ifdef FIFO_RD_UFLOW_STICKY_EN
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("sticky_set", 32'(underflow), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("sticky_hold", 32'(underflow), 1);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sticky_flush_clr", 32'(underflow), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Parametrised read-side controller for the single-clock FIFO: it owns the read pointer, decides whether a read request may be accepted, and drives the synchronous FIFO RAM read port. Occupancy comes from true pointer comparison against the write-side pointer, not from data contents, so zero-valued words are legal. It produces empty and almost-empty flags, an underflow flag, and a `data_valid` strobe aligned with RAM read data. It sits between the FIFO write control, the FIFO RAM and the consumer.

## Interface
- `DATA_W`, 8: word width.
- `DEPTH`, 16: FIFO depth. Must be a power of two, at least 2.
- `AE_THRESH`, 2: `almost_empty` is asserted when `count <= AE_THRESH`. Valid range is 0 to DEPTH-1.
- Derived: `ADDR_W = $clog2(DEPTH)`. Pointers are `ADDR_W+1` bits wide; the MSB is the wrap bit.
- `clk`, in, 1: single clock. Everything is sampled on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `read_en`, in, 1: consumer read request for the current cycle.
- `flush`, in, 1: synchronous discard of all stored words.
- `wr_ptr`, in, ADDR_W+1: write pointer from write control. It is registered on the write side.
- `mem_rdata`, in, DATA_W: RAM read data. It is valid one cycle after `mem_re`.
- `mem_re`, out, 1: RAM read enable (combinational).
- `rd_addr`, out, ADDR_W: RAM read address, equal to `rd_ptr[ADDR_W-1:0]`.
- `rd_ptr`, out, ADDR_W+1: registered read pointer, fed back to write control for the full calculation.
- `count`, out, ADDR_W+1: occupancy, computed as `(wr_ptr - rd_ptr) mod 2^(ADDR_W+1)`.
- `empty`, out, 1: `count == 0`.
- `almost_empty`, out, 1: `count <= AE_THRESH`.
- `data_out`, out, DATA_W: consumer data, passed straight through from `mem_rdata`.
- `data_valid`, out, 1: registered; `data_out` is valid while it is high.
- `underflow`, out, 1: registered read-on-empty error.

## Operation
- **Accept condition:** `accept = read_en & ~empty & ~flush`.
  - `mem_re = accept`.
  - `rd_addr` presents the current pointer in the same cycle.
- **On accept:**
  - `rd_ptr <= rd_ptr + 1`, modulo `2*DEPTH`. From `2*DEPTH-1` it wraps to 0 and the wrap bit toggles.
  - `data_valid <= 1` on the next edge.
- **No accept:** `data_valid <= 0`.
- **Read on empty** (`read_en & empty & ~flush`):
  - Pointer does not move, `mem_re = 0`.
  - `underflow <= 1` for one cycle (pulse).
- **Flush:** `rd_ptr <= wr_ptr`, `data_valid <= 0`, `underflow <= 0`.
  - `flush` has priority over `read_en` in the same cycle: no accept and no underflow.
- **Write and read in the same cycle:** `count` reflects only the registered pointers. A word written this cycle is not readable until `wr_ptr` updates, so reading a FIFO whose `count == 0` before the write edge is an underflow.
- **Full boundary:** `count == DEPTH` is full and legal.
  - `count > DEPTH` is an upstream protocol violation; a bench assertion flags it.
- **No state machine:** control is the pointer register plus the flag logic.

## Timing
- **Reset values:** all outputs return to 0 immediately when reset asserts, whatever the clock is doing.
  - This includes `rd_ptr`, `data_valid` and `underflow`.
  - `empty` and `count` then follow `wr_ptr`, which write control also clears to 0.
- **Reset mid-operation:** a `data_valid` that was due on the next cycle is dropped.
- **Read latency:** if a read is accepted at edge N, `data_valid` is high and `data_out` is valid during cycle N+1.
- **Throughput:** back-to-back reads are accepted every cycle while `count > 0`.
- **Flags:** `empty`, `almost_empty`, `count` and `mem_re` are combinational from registered pointers and inputs.
  - They update in the cycle after a pointer change.
- **Underflow timing:** `underflow` asserts the cycle after the offending request.

## Configuration
- Macro: `FIFO_RD_UFLOW_STICKY_EN`.
- **Defined:** `underflow` is sticky. It sets on the first read-on-empty and holds until `reset` asserts or `flush` is seen.
- **Not defined:** `underflow` is the single-cycle pulse described under Operation.
- The port list is identical in both builds.

## Structure
- Package `fifo_pkg` holds:
  - Default `DATA_W`, `DEPTH` and `AE_THRESH` constants.
  - A `ptr_t` typedef parametrised through a `ptr_w(depth)` function that returns `$clog2(depth)+1`.
  - The `fifo_flags_t` packed struct: `empty`, `almost_empty`, `underflow`.
- One sub-module, `fifo_ptr_cnt`: the wrap-bit pointer register with increment, load (used for flush) and asynchronous active-low clear.
  - The write-side controller is to reuse the same sub-module.

## Test plan
- **Reset then idle:** DEPTH=16, reset low for 3 cycles then released, `read_en=0`.
  - All outputs 0, except `empty=1` and `almost_empty=1`.
- **Fill and drain:** write 0x00, 0x5A, 0xFF, then `read_en=1` for 4 cycles.
  - `data_valid` is high for 3 cycles with data 0x00, 0x5A, 0xFF.
  - The 4th request gives `underflow=1` and `rd_ptr=3`.
- **Wrap:** 40 write/read pairs at DEPTH=16.
  - `rd_ptr` goes 31 → 0.
  - No false `empty`, data order is preserved.
- **Full:** `count=16` with `wr_ptr=16` and `rd_ptr=0`.
  - `empty=0`; one read makes `count=15`.
- **Flush plus read:** `count=5`, `flush=1` and `read_en=1` in the same cycle.
  - `mem_re=0`, `rd_ptr=wr_ptr`, `count=0` next cycle, no `data_valid`.
- **Sticky underflow (macro defined):** read on empty.
  - `underflow` stays 1 across 10 idle cycles and clears only on `flush`.
